vend_controller: RTL and testbench
==================================

# vend_controller

Main vending-machine control FSM. Accumulates inserted coin credit, validates product selections against per-product prices, and sequences dispense and change return. Drives the 2-bit mode input of the downstream countdown timer and consumes its registered timeout flag to close each phase: selection window, product-return window, change-return window.

## Interface

- PRICE_0, 8'd12: price of product 0, in credit units
- PRICE_1, 8'd15: price of product 1
- PRICE_2, 8'd20: price of product 2
- PRICE_3, 8'd25: price of product 3
- MAX_CREDIT, 8'd99: credit ceiling; a coin that would exceed it is rejected
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- coin_valid  in  1  one-cycle strobe, coin inserted
- coin_value  in  2  denomination: 00=1, 01=2, 10=5, 11=10 units
- sel_valid  in  1  one-cycle strobe, product selected
- sel_id  in  2  selected product index
- cancel  in  1  one-cycle strobe, user abort
- timeout  in  1  timer flag, registered, clears one cycle after a mode change
- timer_mode  out  2  00 WAIT_SELECT, 01 PRODUCT_RETURN, 10 CHANGE_RETURN, 11 IDLE/restart
- credit  out  8  current accumulated credit
- coin_reject  out  1  one-cycle pulse, coin not accepted
- sel_reject  out  1  one-cycle pulse, selection refused
- product_out  out  1  one-cycle pulse, dispense
- product_id  out  2  index of dispensed product, held until next dispense
- change_valid  out  1  one-cycle pulse, change released
- change_amount  out  8  change value, held until next change_valid
- busy  out  1  high in VEND and CHANGE

## Operation

- States: IDLE, RESTART, CREDIT, VEND, CHANGE.
- timer_mode by state: IDLE 11, RESTART 11, CREDIT 00, VEND 01, CHANGE 10.
- armed bit: cleared on every timer_mode change. Set after timer_mode has been stable one full cycle. timeout is acted on only when armed=1, so the stale flag from the previous mode is ignored.
- IDLE: accepted coin adds its value to credit and goes to RESTART. sel_valid raises sel_reject. cancel is ignored.
- RESTART: single cycle, then CREDIT. The transition through mode 11 reloads the timer's 30-count. Inputs in this cycle follow the CREDIT rules.
- CREDIT, priority cancel > armed timeout > sel_valid > coin_valid. Lower-priority strobes in the same cycle are dropped; a dropped coin raises coin_reject.
  - cancel or armed timeout goes to CHANGE if credit>0, else IDLE.
  - sel_valid with credit >= PRICE[sel_id]: credit -= price, product_id <= sel_id, product_out pulse, go VEND.
  - sel_valid with insufficient credit raises sel_reject and stays in CREDIT; the timer is not restarted.
  - Coin with credit+value <= MAX_CREDIT is added and goes to RESTART. Otherwise coin_reject; credit is unchanged.
- VEND: coins rejected, selections raise sel_reject, cancel ignored. Armed timeout goes to CHANGE if credit>0, else IDLE.
- CHANGE: on entry, change_amount <= credit, credit <= 0, change_valid pulse. All coins are rejected. Armed timeout goes to IDLE.
- Credit arithmetic: 8-bit unsigned compare on a 9-bit sum; no wrap is possible.

## Timing

- Reset values: state IDLE, timer_mode 11, credit 0, armed 0, product_id 0, change_amount 0. All pulses 0, busy 0.
- All outputs registered. Pulses, credit, and timer_mode update on the clock edge that samples the causing strobe.
- Accepted coin in CREDIT: timer_mode reads 11 for exactly one cycle, then 00.
- Minimum phase length: timeout ignored for the first 2 cycles after any timer_mode change.
- Reset mid-operation returns to IDLE immediately. Pending credit is discarded; no change_valid is issued.

## Test plan

- Reset, then coin 11 (10) and coin 10 (5): credit 15, timer_mode sequence 11,11,00,11,00; select product 1 → product_out, product_id=1, credit 0, timer_mode 01; after timeout → IDLE, no change_valid.
- Credit 20, select product 0 (12) → product_out; after timer timeout → change_valid with change_amount=8, credit 0, mode 10, then IDLE.
- Credit 10, select product 3 (25) → sel_reject, credit stays 10, state CREDIT, timer_mode stays 00.
- Credit 95, insert 10 → coin_reject, credit 95; insert 2 → credit 97.
- Credit 7, sel_valid and cancel in the same cycle → no product_out, change_valid with 7.
- Credit 5, timeout held high across the RESTART → CREDIT transition → ignored for 2 cycles; a later genuine timeout → change_valid 5; rst_n low mid-CHANGE → all outputs at reset values.

Source files
------------

// File: rtl/vend_controller.sv
// vend_controller: coin credit, selection, dispense and change sequencing.
// Drives the countdown timer mode and gates its registered timeout flag.
module vend_controller #(
    parameter logic [7:0] PRICE_0    = 8'd12,
    parameter logic [7:0] PRICE_1    = 8'd15,
    parameter logic [7:0] PRICE_2    = 8'd20,
    parameter logic [7:0] PRICE_3    = 8'd25,
    parameter logic [7:0] MAX_CREDIT = 8'd99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       sel_valid,
    input  logic [1:0] sel_id,
    input  logic       cancel,
    input  logic       timeout,
    output logic [1:0] timer_mode,
    output logic [7:0] credit,
    output logic       coin_reject,
    output logic       sel_reject,
    output logic       product_out,
    output logic [1:0] product_id,
    output logic       change_valid,
    output logic [7:0] change_amount,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESTART,
        S_CREDIT,
        S_VEND,
        S_CHANGE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] credit_nxt;
    logic [7:0] change_amount_nxt;
    logic [1:0] product_id_nxt;
    logic       coin_reject_nxt;
    logic       sel_reject_nxt;
    logic       product_out_nxt;
    logic       change_valid_nxt;
    logic [1:0] mode_nxt;
    logic       mode_same;
    logic       stable;
    logic       armed;
    logic       expire;
    logic [3:0] coin_units;
    logic [7:0] price;
    logic [8:0] coin_sum;
    logic       coin_fits;
    logic       can_buy;
    logic       busy_nxt;

    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            S_CREDIT: mode_of = 2'b00;
            S_VEND:   mode_of = 2'b01;
            S_CHANGE: mode_of = 2'b10;
            default:  mode_of = 2'b11;
        endcase
    endfunction

    always_comb begin
        coin_units = 4'd1;
        unique case (coin_value)
            2'b00: coin_units = 4'd1;
            2'b01: coin_units = 4'd2;
            2'b10: coin_units = 4'd5;
            2'b11: coin_units = 4'd10;
        endcase
    end

    always_comb begin
        price = PRICE_0;
        unique case (sel_id)
            2'b00: price = PRICE_0;
            2'b01: price = PRICE_1;
            2'b10: price = PRICE_2;
            2'b11: price = PRICE_3;
        endcase
    end

    assign coin_sum  = {1'b0, credit} + {5'd0, coin_units};
    assign coin_fits = coin_sum <= {1'b0, MAX_CREDIT};
    assign can_buy   = credit >= price;
    assign expire    = armed & timeout;

    always_comb begin
        state_nxt         = state;
        credit_nxt        = credit;
        product_id_nxt    = product_id;
        change_amount_nxt = change_amount;
        coin_reject_nxt   = 1'b0;
        sel_reject_nxt    = 1'b0;
        product_out_nxt   = 1'b0;
        change_valid_nxt  = 1'b0;
        unique case (state)
            S_IDLE: begin
                sel_reject_nxt = sel_valid;
                if (coin_valid) begin
                    credit_nxt = coin_sum[7:0];
                    state_nxt  = S_RESTART;
                end
            end
            S_RESTART, S_CREDIT: begin
                state_nxt = S_CREDIT;
                if (cancel || expire) begin
                    coin_reject_nxt = coin_valid;
                    state_nxt = (credit != 8'd0) ? S_CHANGE : S_IDLE;
                end else if (sel_valid) begin
                    coin_reject_nxt = coin_valid;
                    if (can_buy) begin
                        credit_nxt      = credit - price;
                        product_id_nxt  = sel_id;
                        product_out_nxt = 1'b1;
                        state_nxt       = S_VEND;
                    end else begin
                        sel_reject_nxt = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_fits) begin
                        credit_nxt = coin_sum[7:0];
                        state_nxt  = S_RESTART;
                    end else begin
                        coin_reject_nxt = 1'b1;
                    end
                end
            end
            S_VEND: begin
                coin_reject_nxt = coin_valid;
                sel_reject_nxt  = sel_valid;
                if (expire)
                    state_nxt = (credit != 8'd0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                coin_reject_nxt = coin_valid;
                if (expire)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Entering CHANGE releases whatever credit remains.
        if (state_nxt == S_CHANGE && state != S_CHANGE) begin
            change_valid_nxt  = 1'b1;
            change_amount_nxt = credit_nxt;
            credit_nxt        = 8'd0;
        end
    end

    assign mode_nxt  = mode_of(state_nxt);
    assign mode_same = mode_nxt == timer_mode;
    assign busy_nxt  = (state_nxt == S_VEND) || (state_nxt == S_CHANGE);

    // Two-stage arming hides the stale flag for two cycles after a mode change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            timer_mode    <= 2'b11;
            credit        <= 8'd0;
            stable        <= 1'b0;
            armed         <= 1'b0;
            product_id    <= 2'd0;
            change_amount <= 8'd0;
            coin_reject   <= 1'b0;
            sel_reject    <= 1'b0;
            product_out   <= 1'b0;
            change_valid  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer_mode    <= mode_nxt;
            credit        <= credit_nxt;
            stable        <= mode_same;
            armed         <= stable & mode_same;
            product_id    <= product_id_nxt;
            change_amount <= change_amount_nxt;
            coin_reject   <= coin_reject_nxt;
            sel_reject    <= sel_reject_nxt;
            product_out   <= product_out_nxt;
            change_valid  <= change_valid_nxt;
            busy          <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed scenarios plus random traffic against a
// behavioural vending model that tracks phase age instead of arm bits.
module tb_vend_controller;

    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       cancel;
    logic       timeout;
    logic [1:0] timer_mode;
    logic [7:0] credit;
    logic       coin_reject;
    logic       sel_reject;
    logic       product_out;
    logic [1:0] product_id;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       busy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    vend_controller dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_id(sel_id),
        .cancel(cancel), .timeout(timeout),
        .timer_mode(timer_mode), .credit(credit),
        .coin_reject(coin_reject), .sel_reject(sel_reject),
        .product_out(product_out), .product_id(product_id),
        .change_valid(change_valid), .change_amount(change_amount),
        .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic void chk(input string n, input logic [8:0] a,
                                input logic [8:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endfunction

    // Behavioural model
    localparam int P_IDLE = 0, P_RESTART = 1, P_CREDIT = 2;
    localparam int P_VEND = 3, P_CHANGE = 4;
    int unit_tab[4]  = '{1, 2, 5, 10};
    int price_tab[4] = '{12, 15, 20, 25};
    int mode_tab[5]  = '{3, 3, 0, 1, 2};
    int m_ph, m_credit, m_pid, m_chg, m_age;
    bit m_cr, m_sr, m_po, m_cv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = P_IDLE; m_credit = 0; m_pid = 0; m_chg = 0; m_age = 0;
            m_cr = 0; m_sr = 0; m_po = 0; m_cv = 0;
        end else begin
            int  nph, v, p;
            bit  to;
            v  = unit_tab[coin_value];
            p  = price_tab[sel_id];
            to = (m_age >= 2) && timeout;
            m_cr = 0; m_sr = 0; m_po = 0; m_cv = 0;
            nph = m_ph;
            if (m_ph == P_IDLE) begin
                m_sr = sel_valid;
                if (coin_valid) begin
                    m_credit += v;
                    nph = P_RESTART;
                end
            end else if (m_ph == P_RESTART || m_ph == P_CREDIT) begin
                nph = P_CREDIT;
                if (cancel || to) begin
                    m_cr = coin_valid;
                    nph = (m_credit > 0) ? P_CHANGE : P_IDLE;
                end else if (sel_valid) begin
                    m_cr = coin_valid;
                    if (m_credit >= p) begin
                        m_credit -= p;
                        m_pid = sel_id;
                        m_po = 1;
                        nph = P_VEND;
                    end else m_sr = 1;
                end else if (coin_valid) begin
                    if (m_credit + v <= 99) begin
                        m_credit += v;
                        nph = P_RESTART;
                    end else m_cr = 1;
                end
            end else if (m_ph == P_VEND) begin
                m_cr = coin_valid;
                m_sr = sel_valid;
                if (to) nph = (m_credit > 0) ? P_CHANGE : P_IDLE;
            end else begin
                m_cr = coin_valid;
                if (to) nph = P_IDLE;
            end
            if (nph == P_CHANGE && m_ph != P_CHANGE) begin
                m_chg = m_credit;
                m_credit = 0;
                m_cv = 1;
            end
            if (mode_tab[nph] != mode_tab[m_ph]) m_age = 0;
            else if (m_age < 3) m_age++;
            m_ph = nph;
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("timer_mode", timer_mode, mode_tab[m_ph]);
        chk("credit", credit, m_credit[8:0]);
        chk("coin_reject", coin_reject, m_cr);
        chk("sel_reject", sel_reject, m_sr);
        chk("product_out", product_out, m_po);
        chk("product_id", product_id, m_pid[8:0]);
        chk("change_valid", change_valid, m_cv);
        chk("change_amount", change_amount, m_chg[8:0]);
        chk("busy", busy, (m_ph == P_VEND || m_ph == P_CHANGE));
    end

    task automatic tick();
        @(posedge clk); #1;
        coin_valid = 0; sel_valid = 0; cancel = 0;
    endtask
    task automatic put(input logic [1:0] v);
        coin_valid = 1; coin_value = v; tick();
    endtask
    task automatic pick(input logic [1:0] id);
        sel_valid = 1; sel_id = id; tick();
    endtask
    task automatic expire();
        tick(); tick(); timeout = 1; tick(); timeout = 0;
    endtask

    initial begin
        int cp, sp, tp, xp;
        rst_n = 0; coin_valid = 0; coin_value = 0; sel_valid = 0;
        sel_id = 0; cancel = 0; timeout = 0;
        @(posedge clk); #1;
        chk_en = 1;
        tick(); rst_n = 1;
        chk("reset mode", timer_mode, 3);
        chk("reset credit", credit, 0);
        tick();

        // Two coins then buy product 1 with exact credit
        put(2'b11);
        chk("t1 credit10", credit, 10);
        chk("t1 mode restart", timer_mode, 3);
        tick();
        chk("t1 mode credit", timer_mode, 0);
        put(2'b10);
        chk("t1 credit15", credit, 15);
        chk("t1 mode restart2", timer_mode, 3);
        tick();
        pick(2'd1);
        chk("t1 product_out", product_out, 1);
        chk("t1 product_id", product_id, 1);
        chk("t1 credit0", credit, 0);
        chk("t1 mode vend", timer_mode, 1);
        expire();
        chk("t1 idle mode", timer_mode, 3);
        chk("t1 no change", change_valid, 0);

        // Buy product 0 from 20, expect change of 8
        put(2'b11); tick(); put(2'b11); tick();
        pick(2'd0);
        chk("t2 product_out", product_out, 1);
        chk("t2 credit8", credit, 8);
        expire();
        chk("t2 change_valid", change_valid, 1);
        chk("t2 change_amount", change_amount, 8);
        chk("t2 mode change", timer_mode, 2);
        expire();
        chk("t2 idle", timer_mode, 3);

        // Insufficient credit
        put(2'b11); tick();
        pick(2'd3);
        chk("t3 sel_reject", sel_reject, 1);
        chk("t3 credit10", credit, 10);
        chk("t3 mode", timer_mode, 0);
        cancel = 1; tick();
        chk("t3 change", change_amount, 10);
        expire();

        // Credit ceiling
        for (int i = 0; i < 9; i++) begin put(2'b11); tick(); end
        put(2'b10); tick();
        chk("t4 credit95", credit, 95);
        put(2'b11);
        chk("t4 coin_reject", coin_reject, 1);
        chk("t4 credit kept", credit, 95);
        put(2'b01);
        chk("t4 credit97", credit, 97);
        tick(); cancel = 1; tick(); expire();

        // Cancel beats selection
        put(2'b10); tick(); put(2'b01); tick();
        sel_valid = 1; sel_id = 0; cancel = 1; tick();
        chk("t5 no product", product_out, 0);
        chk("t5 change7", change_amount, 7);
        chk("t5 change_valid", change_valid, 1);
        expire();

        // Stale timeout across RESTART->CREDIT, then reset mid-CHANGE
        put(2'b01); tick(); put(2'b01); tick(); put(2'b00);
        timeout = 1; tick(); tick(); tick(); timeout = 0;
        chk("t6 still credit", timer_mode, 0);
        chk("t6 credit5", credit, 5);
        expire();
        chk("t6 change5", change_amount, 5);
        chk("t6 change_valid", change_valid, 1);
        tick();
        rst_n = 0; #1;
        chk("t6 rst mode", timer_mode, 3);
        chk("t6 rst credit", credit, 0);
        chk("t6 rst change_amount", change_amount, 0);
        chk("t6 rst busy", busy, 0);
        tick(); rst_n = 1; tick();

        // Random traffic: first coin-heavy, then balanced
        for (int seg = 0; seg < 2; seg++) begin
            cp = seg == 0 ? 2 : 4;
            sp = seg == 0 ? 12 : 5;
            tp = seg == 0 ? 200 : 8;
            xp = seg == 0 ? 300 : 40;
            for (int i = 0; i < 2000; i++) begin
                coin_valid = ($urandom_range(0, cp - 1) == 0);
                coin_value = 2'($urandom_range(0, 3));
                sel_valid  = ($urandom_range(0, sp - 1) == 0);
                sel_id     = 2'($urandom_range(0, 3));
                cancel     = ($urandom_range(0, xp - 1) == 0);
                timeout    = ($urandom_range(0, tp - 1) == 0);
                rst_n      = ($urandom_range(0, 599) != 0);
                @(posedge clk); #1;
            end
        end
        rst_n = 1; coin_valid = 0; sel_valid = 0; cancel = 0; timeout = 0;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
